// File: rtl/mtip_reg_pkg.sv
package mtip_reg_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WAIT  = 2'd1,
    ACK   = 2'd2,
    RECOV = 2'd3
  } state_t;

  localparam logic [7:0]  REG_REVISION  = 8'd0;
  localparam logic [7:0]  REG_STATUS    = 8'd1;
  localparam logic [7:0]  REG_CTRL      = 8'd2;

  localparam logic [31:0] DEF_REVISION  = 32'h0001_0000;
  localparam logic [31:0] DEF_CTRL_RST  = 32'h0000_0020;
  localparam logic [31:0] BAD_ADDR_DATA = 32'h0000_0000;

endpackage

// File: rtl/mtip_sat_cnt.sv
module mtip_sat_cnt (
  input  logic        clk,
  input  logic        rst,
  input  logic        inc,
  input  logic        clr,
  output logic [15:0] cnt
);

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      cnt <= '0;
    end else if (inc && (cnt != '1)) begin
      cnt <= cnt + 16'd1;
    end
  end

endmodule

// File: rtl/mtip_reg_target.sv
module mtip_reg_target
  import mtip_reg_pkg::*;
#(
  parameter int unsigned NUM_REGS = 16,
  parameter int unsigned WAIT_CYC = 2,
  parameter logic [31:0] REVISION = DEF_REVISION,
  parameter logic [31:0] CTRL_RST = DEF_CTRL_RST
) (
  input  logic                  iCLK_100M,
  input  logic                  iRST_100M,
  input  logic [9:0]            iREG_ADDR,
  input  logic [31:0]           iREG_DATA_IN,
  input  logic                  iREG_RD,
  input  logic                  iREG_WR,
  output logic [31:0]           oREG_DATA_OUT,
  output logic                  oREG_BUSY,
  output logic [NUM_REGS*32-1:0] oREG_FILE,
  output logic [NUM_REGS-1:0]   oREG_WR_PULSE
);

  localparam int unsigned IDXW      = $clog2(NUM_REGS);
  localparam logic [8:0]  NREGS9    = 9'(NUM_REGS);
  localparam logic [3:0]  WAIT_INIT = (WAIT_CYC == 0) ? 4'd0 : 4'(WAIT_CYC - 1);

  state_t      state, next_state;
  logic [3:0]  cnt, next_cnt;
  logic [7:0]  lat_idx;
  logic [31:0] lat_data;
  logic        lat_wr;

  logic        req, sample, enter_ack, abort;
  logic [7:0]  acc_idx;
  logic [31:0] acc_data;
  logic        acc_wr, acc_bad;
  logic        commit, err_inc, status_clr;
  logic [31:0] rd_val;
  logic [15:0] err_cnt, abort_cnt;

  logic [31:0] regs  [2:NUM_REGS-1];
  logic [31:0] words [NUM_REGS];

  logic        addr_lsb_unused;
  assign addr_lsb_unused = ^iREG_ADDR[1:0];

  assign req = iREG_RD | iREG_WR;

  // With WAIT_CYC=0 the commit happens on the sampling edge, so the
  // transaction fields come from the live inputs while in IDLE.
  assign acc_idx  = (state == IDLE) ? iREG_ADDR[9:2] : lat_idx;
  assign acc_data = (state == IDLE) ? iREG_DATA_IN   : lat_data;
  assign acc_wr   = (state == IDLE) ? iREG_WR        : lat_wr;
  assign acc_bad  = ({1'b0, acc_idx} >= NREGS9);

  always_comb begin
    next_state = state;
    next_cnt   = cnt;
    sample     = 1'b0;
    enter_ack  = 1'b0;
    abort      = 1'b0;
    case (state)
      IDLE: begin
        if (req) begin
          sample = 1'b1;
          if (WAIT_CYC == 0) begin
            next_state = ACK;
            enter_ack  = 1'b1;
          end else begin
            next_state = WAIT;
            next_cnt   = WAIT_INIT;
          end
        end
      end
      WAIT: begin
        if (!req) begin
          abort      = 1'b1;
          next_state = IDLE;
        end else if (cnt == 4'd0) begin
          next_state = ACK;
          enter_ack  = 1'b1;
        end else begin
          next_cnt = cnt - 4'd1;
        end
      end
      ACK:     next_state = RECOV;
      RECOV:   if (!req) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  assign commit     = enter_ack & acc_wr & ~acc_bad & (acc_idx != REG_REVISION);
  assign status_clr = commit & (acc_idx == REG_STATUS);
  assign err_inc    = sample & (acc_bad | (iREG_RD & iREG_WR));

  always_comb begin
    words[0] = REVISION;
    words[1] = {abort_cnt, err_cnt};
    for (int unsigned i = 2; i < NUM_REGS; i++) begin
      words[i] = regs[i];
    end
  end

  always_comb begin
    oREG_FILE = '0;
    for (int unsigned i = 0; i < NUM_REGS; i++) begin
      oREG_FILE[32*i +: 32] = words[i];
    end
  end

  assign rd_val = acc_bad ? BAD_ADDR_DATA : words[acc_idx[IDXW-1:0]];

  always_ff @(posedge iCLK_100M) begin
    if (iRST_100M) begin
      state         <= IDLE;
      cnt           <= '0;
      lat_idx       <= '0;
      lat_data      <= '0;
      lat_wr        <= 1'b0;
      oREG_BUSY     <= 1'b1;
      oREG_DATA_OUT <= '0;
      oREG_WR_PULSE <= '0;
    end else begin
      state         <= next_state;
      cnt           <= next_cnt;
      oREG_BUSY     <= (next_state != ACK);
      oREG_WR_PULSE <= '0;
      if (sample) begin
        lat_idx  <= iREG_ADDR[9:2];
        lat_data <= iREG_DATA_IN;
        lat_wr   <= iREG_WR;
      end
      if (enter_ack) begin
        oREG_DATA_OUT <= acc_wr ? '0 : rd_val;
      end
      if (commit) begin
        oREG_WR_PULSE[acc_idx[IDXW-1:0]] <= 1'b1;
      end
    end
  end

  always_ff @(posedge iCLK_100M) begin
    if (iRST_100M) begin
      for (int unsigned i = 2; i < NUM_REGS; i++) begin
        regs[i] <= (i == 32'(REG_CTRL)) ? CTRL_RST : '0;
      end
    end else if (commit && (acc_idx > REG_STATUS)) begin
      regs[acc_idx[IDXW-1:0]] <= acc_data;
    end
  end

  mtip_sat_cnt u_err_cnt (
    .clk (iCLK_100M),
    .rst (iRST_100M),
    .inc (err_inc),
    .clr (status_clr),
    .cnt (err_cnt)
  );

  mtip_sat_cnt u_abort_cnt (
    .clk (iCLK_100M),
    .rst (iRST_100M),
    .inc (abort),
    .clr (status_clr),
    .cnt (abort_cnt)
  );

endmodule

// File: tb/tb_mtip_reg_target.sv
module tb_mtip_reg_target;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic [2:0]       rd = '0, wr = '0, busy;
  logic [2:0][9:0]  addr = '0;
  logic [2:0][31:0] din = '0, dout;
  logic [2:0][15:0] pulse;
  logic [2:0][511:0] file;

  int checks = 0;
  int errors = 0;

  logic [47:0] q0[$], q1[$], q2[$];

  always #5 clk = ~clk;

  function automatic int wc(input int g);
    return (g == 0) ? 2 : ((g == 1) ? 4 : 0);
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual %h required %h", nm, act, exp);
    end
  endtask

  task automatic qpush(input int g, input logic [47:0] v);
    case (g)
      0: q0.push_back(v);
      1: q1.push_back(v);
      default: q2.push_back(v);
    endcase
  endtask

  task automatic qpop(input int g, output logic ok, output logic [47:0] v);
    ok = 1'b1;
    v  = '0;
    case (g)
      0: if (q0.size() != 0) v = q0.pop_front(); else ok = 1'b0;
      1: if (q1.size() != 0) v = q1.pop_front(); else ok = 1'b0;
      default: if (q2.size() != 0) v = q2.pop_front(); else ok = 1'b0;
    endcase
  endtask

  for (genvar g = 0; g < 3; g++) begin : g_dut
    logic [47:0] e;
    logic        ok;

    mtip_reg_target #(
      .NUM_REGS (16),
      .WAIT_CYC ((g == 0) ? 2 : ((g == 1) ? 4 : 0))
    ) u_dut (
      .iCLK_100M     (clk),
      .iRST_100M     (rst),
      .iREG_ADDR     (addr[g]),
      .iREG_DATA_IN  (din[g]),
      .iREG_RD       (rd[g]),
      .iREG_WR       (wr[g]),
      .oREG_DATA_OUT (dout[g]),
      .oREG_BUSY     (busy[g]),
      .oREG_FILE     (file[g]),
      .oREG_WR_PULSE (pulse[g])
    );

    always @(negedge clk) begin
      if (!rst) begin
        if (!busy[g]) begin
          qpop(g, ok, e);
          if (!ok) begin
            checks++;
            errors++;
            $display("FAIL ack_unexpected[%0d]: actual ack with data %h required no ack", g, dout[g]);
          end else begin
            chk($sformatf("ack_data[%0d]", g), 64'(dout[g]), 64'(e[47:16]));
            chk($sformatf("ack_pulse[%0d]", g), 64'(pulse[g]), 64'(e[15:0]));
          end
        end else begin
          chk($sformatf("idle_pulse[%0d]", g), 64'(pulse[g]), 64'd0);
        end
      end
    end
  end

  task automatic access(input int g, input logic r, input logic w, input logic [9:0] a,
                        input logic [31:0] d, input logic [31:0] xd, input logic [15:0] xp,
                        input int hold);
    int n;
    qpush(g, {xd, xp});
    addr[g] = a;
    din[g]  = d;
    rd[g]   = r;
    wr[g]   = w;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (busy[g] && n < 40);
    chk($sformatf("ack_latency[%0d]", g), 64'(n), 64'(wc(g) + 1));
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      chk($sformatf("recov_busy[%0d]", g), 64'(busy[g]), 64'd1);
    end
    rd[g] = 1'b0;
    wr[g] = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  initial begin
    #200000;
    errors++;
    $display("FAIL watchdog: actual timeout required completion");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $fatal(1);
  end

  initial begin
    repeat (3) @(negedge clk);
    for (int g = 0; g < 3; g++) begin
      chk("rst_busy", 64'(busy[g]), 64'd1);
      chk("rst_dout", 64'(dout[g]), 64'd0);
      chk("rst_pulse", 64'(pulse[g]), 64'd0);
    end
    chk("rst_file_rev", 64'(file[0][31:0]), 64'h0001_0000);
    chk("rst_file_ctrl", 64'(file[0][95:64]), 64'h0000_0020);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // WAIT_CYC=2 instance
    access(0, 1, 0, 10'h008, 32'h0,         32'h0000_0020, 16'h0000, 0);
    access(0, 1, 0, 10'h000, 32'h0,         32'h0001_0000, 16'h0000, 0);
    access(0, 0, 1, 10'h000, 32'hFFFF_FFFF, 32'h0,         16'h0000, 0);
    access(0, 1, 0, 10'h000, 32'h0,         32'h0001_0000, 16'h0000, 0);
    access(0, 0, 1, 10'h00C, 32'hA5A5_5A5A, 32'h0,         16'h0008, 0);
    access(0, 1, 0, 10'h00C, 32'h0,         32'hA5A5_5A5A, 16'h0000, 0);
    access(0, 1, 0, 10'h3FC, 32'h0,         32'h0,         16'h0000, 0);
    access(0, 0, 1, 10'h3FC, 32'h1234_5678, 32'h0,         16'h0000, 0);
    access(0, 1, 1, 10'h3FC, 32'h1234_5678, 32'h0,         16'h0000, 0);
    access(0, 1, 0, 10'h004, 32'h0,         32'h0000_0003, 16'h0000, 0);

    // reset while the CTRL write sits in WAIT
    addr[0] = 10'h008;
    din[0]  = 32'hDEAD_BEEF;
    wr[0]   = 1'b1;
    @(negedge clk);
    rst   = 1'b1;
    wr[0] = 1'b0;
    @(negedge clk);
    chk("midrst_busy", 64'(busy[0]), 64'd1);
    chk("midrst_pulse", 64'(pulse[0]), 64'd0);
    chk("midrst_ctrl", 64'(file[0][95:64]), 64'h0000_0020);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    access(0, 1, 0, 10'h008, 32'h0, 32'h0000_0020, 16'h0000, 0);
    access(0, 1, 0, 10'h00C, 32'h0, 32'h0,         16'h0000, 0);
    access(0, 1, 0, 10'h004, 32'h0, 32'h0,         16'h0000, 0);

    // WAIT_CYC=4 instance: abort then status clear
    addr[1] = 10'h004;
    rd[1]   = 1'b1;
    @(negedge clk);
    rd[1] = 1'b0;
    repeat (6) @(negedge clk);
    access(1, 1, 0, 10'h004, 32'h0,         32'h0001_0000, 16'h0000, 0);
    access(1, 0, 1, 10'h004, 32'h1234_5678, 32'h0,         16'h0002, 0);
    access(1, 1, 0, 10'h004, 32'h0,         32'h0,         16'h0000, 0);

    // WAIT_CYC=0 instance: strobe held one cycle past the ack
    access(2, 0, 1, 10'h00C, 32'h0000_5555, 32'h0,         16'h0008, 1);
    chk("hold_file_w3", 64'(file[2][127:96]), 64'h0000_5555);
    access(2, 1, 0, 10'h00C, 32'h0,         32'h0000_5555, 16'h0000, 0);
    access(2, 1, 0, 10'h004, 32'h0,         32'h0,         16'h0000, 0);

    repeat (4) @(negedge clk);
    chk("q0_empty", 64'(q0.size()), 64'd0);
    chk("q1_empty", 64'(q1.size()), 64'd0);
    chk("q2_empty", 64'(q2.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
